// File: rtl/feistel_pkg.sv
// feistel_pkg: shared FSM state type, legal half-widths and round-key index helper
package feistel_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FINAL, DONE} state_t;
  localparam int HALF_W_32 = 32;
  localparam int HALF_W_64 = 64;
  function automatic int key_idx(input int r, input logic encrypt, input int rounds);
    return encrypt ? r : rounds + 1 - r;
  endfunction
endpackage

// File: rtl/feistel_stream_core_key_sel.sv
// feistel_key_sel: picks round key KR (i_keys, i_r, i_encrypt -> o_kr) and whitening keys (o_wl, o_wr)
module feistel_key_sel
  import feistel_pkg::*;
#(
  parameter int HALF_W = 64,
  parameter int ROUNDS = 8,
  localparam int RW = $clog2(ROUNDS + 1)
) (
  input  logic [(ROUNDS+2)*HALF_W-1:0] i_keys,
  input  logic [RW-1:0]                i_r,
  input  logic                         i_encrypt,
  output logic [HALF_W-1:0]            o_kr,
  output logic [HALF_W-1:0]            o_wl,
  output logic [HALF_W-1:0]            o_wr
);
  always_comb begin
    o_kr = '0;
    for (int i = 0; i < ROUNDS + 2; i++)
      if (key_idx(int'(i_r), i_encrypt, ROUNDS) == i) o_kr = i_keys[i*HALF_W +: HALF_W];
    o_wl = i_encrypt ? i_keys[(ROUNDS+1)*HALF_W +: HALF_W] : i_keys[0 +: HALF_W];
    o_wr = i_encrypt ? i_keys[ROUNDS*HALF_W +: HALF_W] : i_keys[HALF_W +: HALF_W];
  end
endmodule

// File: rtl/feistel_stream_core.sv
// feistel_stream_core: valid/ready Feistel engine; block in/out, F-function req/strobe (X, ffuncEnable, Y, ffuncReady), abort flag
module feistel_stream_core
  import feistel_pkg::*;
#(
  parameter int HALF_W = 64,
  parameter int ROUNDS = 8
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Flush,
  input  logic                         skeyReady,
  input  logic [(ROUNDS+2)*HALF_W-1:0] keys,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic [2*HALF_W-1:0]          inBlock,
  input  logic                         inEncrypt,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [2*HALF_W-1:0]          outBlock,
  output logic [HALF_W-1:0]            X,
  output logic                         ffuncEnable,
  input  logic [HALF_W-1:0]            Y,
  input  logic                         ffuncReady,
  output logic                         abortPulse
);
  localparam int RW = $clog2(ROUNDS + 1);
  if (HALF_W != HALF_W_32 && HALF_W != HALF_W_64) begin : g_bad_half_w
    $error("HALF_W must be 32 or 64");
  end
  state_t r_state;
  logic [HALF_W-1:0] r_lh, r_rh, w_kr, w_wl, w_wr;
  logic [RW-1:0] r_rnd;
  logic r_enc, w_busy, w_abort;
  feistel_key_sel #(.HALF_W(HALF_W), .ROUNDS(ROUNDS)) u_key_sel (
    .i_keys(keys), .i_r(r_rnd), .i_encrypt(r_enc), .o_kr(w_kr), .o_wl(w_wl), .o_wr(w_wr)
  );
  assign inReady  = (r_state == IDLE) && skeyReady;
  assign outValid = r_state == DONE;
  assign w_busy   = r_state == ISSUE || r_state == WAIT || r_state == FINAL;
  assign w_abort  = (w_busy && (Flush || !skeyReady)) || (r_state == DONE && Flush);
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_lh        <= '0;
      r_rh        <= '0;
      r_rnd       <= '0;
      r_enc       <= 1'b0;
      X           <= '0;
      ffuncEnable <= 1'b0;
      outBlock    <= '0;
      abortPulse  <= 1'b0;
    end else begin
      abortPulse <= w_abort;
      if (w_abort) begin
        r_state     <= IDLE;
        ffuncEnable <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (inValid && inReady) begin
            r_lh    <= inBlock[2*HALF_W-1:HALF_W];
            r_rh    <= inBlock[HALF_W-1:0];
            r_enc   <= inEncrypt;
            r_rnd   <= '0;
            r_state <= ISSUE;
          end
          ISSUE: begin
            X           <= r_lh ^ w_kr;
            ffuncEnable <= 1'b1;
            r_state     <= WAIT;
          end
          WAIT: if (ffuncReady) begin
            r_lh        <= r_rh ^ Y;
            r_rh        <= X;
            r_rnd       <= r_rnd + 1'b1;
            ffuncEnable <= 1'b0;
            r_state     <= (r_rnd == RW'(ROUNDS - 1)) ? FINAL : ISSUE;
          end
          FINAL: begin
            outBlock <= {r_rh ^ w_wl, r_lh ^ w_wr};
            r_state  <= DONE;
          end
          DONE: if (outReady) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/feistel_stream_core.md
# feistel_stream_core

Parametrised streaming Feistel engine, the successor to the fixed 128-bit Blowfish core. It takes one block at a time over a valid/ready input, runs `ROUNDS` Feistel rounds against an external F-function over a request/strobe handshake, and applies output whitening. The result is held on a valid/ready output. Sits between the subkey generator, which supplies the key array and `skeyReady`, and the system stream fabric; the F-function stays a separate block.

## Interface
- `HALF_W`, default 64: half-block width; legal values 32 and 64; block width = 2·`HALF_W`.
- `ROUNDS`, default 8: number of Feistel rounds; even, ≥2.
- `Clk` in 1: clock, rising edge.
- `Rst` in 1: reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `Flush` in 1: synchronous abort; returns the core to IDLE and discards any block in flight.
- `skeyReady` in 1: subkeys valid.
- `keys` in (`ROUNDS`+2)·`HALF_W`: key array; K[i] = `keys[i·HALF_W +: HALF_W]`, i = 0..`ROUNDS`+1.
- `inValid` in 1: input block valid.
- `inReady` out 1: core can accept a block.
- `inBlock` in 2·`HALF_W`: block; left half = MSBs.
- `inEncrypt` in 1: mode for this block; 1 = encrypt, 0 = decrypt.
- `outValid` out 1: result valid.
- `outReady` in 1: downstream accepts the result.
- `outBlock` out 2·`HALF_W`: result.
- `X` out `HALF_W`: F-function operand.
- `ffuncEnable` out 1: F request.
- `Y` in `HALF_W`: F result.
- `ffuncReady` in 1: one-cycle strobe; `Y` is valid in that cycle.
- `abortPulse` out 1: one-cycle flag that a block was dropped.

## Operation
- **States:**
  - IDLE → ISSUE on accept.
  - ISSUE → WAIT, always.
  - WAIT → ISSUE on `ffuncReady` when r < `ROUNDS`−1.
  - WAIT → FINAL on `ffuncReady` when r = `ROUNDS`−1.
  - FINAL → DONE, always.
  - DONE → IDLE on `outReady`.
- **Accept:** `inReady` = (state == IDLE) & `skeyReady`. A handshake latches lH ← `inBlock[2W−1:W]`, rH ← `inBlock[W−1:0]`, latches the mode bit, and sets r ← 0.
- **Round key:** encrypt uses KR = K[r]; decrypt uses KR = K[`ROUNDS`+1−r].
- **ISSUE:** registers `X` ← lH ^ KR and `ffuncEnable` ← 1.
- **WAIT:** `X` and `ffuncEnable` are held stable. On `ffuncReady`: lH ← rH ^ Y, rH ← X, r ← r+1, `ffuncEnable` ← 0.
- **FINAL:** undoes the last swap and whitens in one cycle.
  - Encrypt: out L = rH ^ K[`ROUNDS`+1], out R = lH ^ K[`ROUNDS`].
  - Decrypt: out L = rH ^ K[0], out R = lH ^ K[1].
- **DONE:** `outValid` = 1. `outBlock` stays stable until `outReady`. Accepting the result returns the core to IDLE.
- **Mode:** the latched mode bit governs the whole block. `inEncrypt` changing mid-block has no effect.
- **Arithmetic:** XOR only; counter width `$clog2(ROUNDS+1)`; no wrap, because r never exceeds `ROUNDS`.
- **Abort:** `Flush` or `skeyReady` low in ISSUE, WAIT or FINAL forces IDLE, sets `ffuncEnable` ← 0, and pulses `abortPulse` for 1 cycle.
  - A late `ffuncReady` arriving after an abort is ignored.
  - In DONE, `skeyReady` low does not abort; the result is already formed. `Flush` in DONE discards the result and pulses `abortPulse`.
- **Priority:** `Rst` > `Flush` > `skeyReady` abort > normal transition.

## Timing
- **Reset values:** state = IDLE; `inReady` = `skeyReady`; `outValid` = 0; `outBlock` = 0; `X` = 0; `ffuncEnable` = 0; `abortPulse` = 0; r = 0.
- **k:** the number of cycles `ffuncEnable` is high before `ffuncReady` is sampled high; k ≥ 1.
- **Round cost:** k+1 cycles.
- **Latency:** `outValid` rises `ROUNDS`·(k+1)+1 cycles after the accept edge. For `ROUNDS` = 8 and k = 1 this is 17 cycles.
- **Throughput:** the next accept is possible the cycle after the `outValid`&`outReady` edge. There is no overlap of blocks.
- `ffuncReady` while `ffuncEnable` is low is ignored.
- `abortPulse` is registered: high in the cycle after the abort condition.

## Structure
- Package `feistel_pkg` holds:
  - the `state_t` enum (IDLE, ISSUE, WAIT, FINAL, DONE);
  - a function `key_idx(r, encrypt, ROUNDS)`;
  - localparams for the legal `HALF_W` values.
- One sub-module, `feistel_key_sel`: combinational mux from `keys`, r and mode to KR and the two whitening keys.
- The FSM and datapath stay in the top module.

## Test plan
- **Zero-key swap:** `HALF_W` = 64, `ROUNDS` = 8, all K = 0, F stub Y = 0, k = 1, encrypt, `inBlock` = {64'hA, 64'hB} → `outBlock` = {64'hB, 64'hA} at 17 cycles.
- **Round-trip:** F stub Y = {X[62:0], X[63]} ^ 64'h5A5A…, k = 3, keys K[i] = i·64'h0101…. Encrypt 128'h0123456789ABCDEF_FEDCBA9876543210, then decrypt the result → the original value.
- **Output backpressure:** hold `outReady` = 0 for 10 cycles → `outBlock` stable, `inReady` = 0. Release → accept on the next cycle.
- **Flush mid-round:** assert `Flush` during WAIT of round 3 → IDLE next cycle, `ffuncEnable` = 0, `abortPulse` for 1 cycle. A late `ffuncReady` is ignored, and the next block completes correctly.
- **Subkey loss mid-block:** `skeyReady` low in ISSUE → abort. `inReady` stays 0 until `skeyReady` returns.
- **`HALF_W` = 32, `ROUNDS` = 16:** zero keys, Y = 0, `inBlock` = 64'h11112222_33334444 → 64'h33334444_11112222 at 33 cycles.
